// File: rtl/fib_job_sequencer.sv
// fib_job_sequencer: buffers Fibonacci index requests, issues them to the core one at a time,
// and returns {err, result} on a valid/ready stream with a watchdog on stuck jobs.
module fib_job_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_err,
    input  logic        out_ready,
    output logic        fib_start,
    output logic [15:0] fib_din,
    input  logic [15:0] fib_dout,
    input  logic        fib_done,
    output logic [15:0] jobs_done
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

    state_t        r_state;
    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic [15:0]   r_wd;
    logic          r_done_q;
    logic          w_push;
    logic          w_pop;
    logic          w_done_rise;
    logic          w_timeout;
    logic [15:0]   w_wd_next;

    assign in_ready    = r_cnt != (AW+1)'(DEPTH);
    assign w_push      = in_valid && in_ready;
    assign w_pop       = r_state == S_IDLE && r_cnt != '0;
    assign w_done_rise = fib_done && !r_done_q;
    assign w_wd_next   = r_wd + 16'd1;
    // Compare the post-increment count so a job spends at most TIMEOUT cycles in S_WAIT.
    assign w_timeout   = w_wd_next == 16'(TIMEOUT);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_done_q  <= 1'b0;
            r_wd      <= '0;
            fib_start <= 1'b0;
            fib_din   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            jobs_done <= '0;
        end else begin
            r_done_q  <= fib_done;
            fib_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        fib_din   <= r_mem[r_rd];
                        fib_start <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wd    <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_wd <= w_wd_next;
                    if (w_done_rise || w_timeout) begin
                        out_data  <= w_done_rise ? fib_dout : 16'hFFFF;
                        out_err   <= !w_done_rise;
                        out_valid <= 1'b1;
                        r_state   <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        jobs_done <= jobs_done + 16'd1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fib_job_sequencer.sv
// tb_fib_job_sequencer: drives the sequencer against a Fibonacci core model with programmable
// latency and done-drop timing, checking every cycle against a transaction-level reference.
module tb_fib_job_sequencer;
    localparam int DEPTH = 4;
    localparam int TO    = 20;
    localparam int STUCK = 1 << 30;

    typedef struct {int l; int d;} cfg_t;
    typedef struct {logic err; logic [15:0] data; int lat;} res_t;

    logic        clk = 0;
    logic        reset = 1;
    logic        in_valid = 0;
    logic [15:0] in_data = 0;
    logic        out_ready = 0;
    logic        fib_done = 0;
    logic [15:0] fib_dout = 0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_err;
    logic        fib_start;
    logic [15:0] fib_din;
    logic [15:0] jobs_done;

    cfg_t        cfg_q[$];
    res_t        res_q[$];
    logic [15:0] mq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    cfg_t        cc;
    int          core_st = 0;
    int          core_l = 3;
    int          core_d = 1;
    logic [15:0] core_n = 0;
    bit          core_busy = 0;
    bit          busy = 0;
    logic [15:0] cur_n = 0;
    logic [15:0] exp_data = 0;
    bit          exp_err = 0;
    bit          prev_valid = 0;
    int          st = 0;
    int          exp_cyc = 0;
    int          lat = 0;
    int          accepted = 0;
    int          starts = 0;
    int          wait_cnt = 0;
    int          last_push = 0;
    int          last_start = 0;
    int          s0 = 0;
    bit          rand_done = 0;

    fib_job_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_err(out_err), .out_ready(out_ready),
        .fib_start(fib_start), .fib_din(fib_din), .fib_dout(fib_dout), .fib_done(fib_done),
        .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] fib(input logic [15:0] n);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] t;
        a = 0;
        b = 1;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Core model: done drops core_d cycles after start and rises core_l cycles after start.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                core_busy = 0;
                fib_done  = 0;
            end else begin
                if (fib_start) begin
                    cc = cfg_q.size() != 0 ? cfg_q.pop_front() : '{3, 1};
                    core_l = cc.l;
                    core_d = cc.d;
                    core_n = fib_din;
                    core_st = cyc;
                    core_busy = 1;
                end
                if (core_busy) begin
                    if (cyc - core_st >= core_d && cyc - core_st < core_l) fib_done = 0;
                    if (cyc - core_st == core_l) begin
                        fib_done = 1;
                        fib_dout = fib(core_n);
                    end
                end
            end
            if (!fib_done) fib_dout = 16'($urandom);
        end
    end

    // Reference: FIFO order of accepted requests, one job in flight, result due after the
    // core's rising done or after TO cycles of waiting, whichever the core allows first.
    always @(negedge clk) begin
        if (reset) begin
            mq.delete();
            busy = 0;
            cur_n = 0;
            accepted = 0;
            wait_cnt = 0;
            prev_valid = 0;
            chk("rst_in_ready", 32'(in_ready), 1);
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_out_data", 32'(out_data), 0);
            chk("rst_out_err", 32'(out_err), 0);
            chk("rst_fib_start", 32'(fib_start), 0);
            chk("rst_fib_din", 32'(fib_din), 0);
            chk("rst_jobs_done", 32'(jobs_done), 0);
        end else begin
            if (fib_start) begin
                chk("start_legal", 32'(!busy && mq.size() != 0), 1);
                if (mq.size() != 0) cur_n = mq.pop_front();
                busy = 1;
                st = cyc;
                starts++;
                last_start = cyc;
                exp_err = core_l > TO;
                exp_cyc = st + (exp_err ? TO : core_l) + 1;
                exp_data = exp_err ? 16'hFFFF : fib(cur_n);
            end
            chk("fib_din", 32'(fib_din), 32'(cur_n));
            wait_cnt = (!busy && mq.size() != 0) ? wait_cnt + 1 : 0;
            chk("issue_wait", 32'(wait_cnt > 1), 0);
            chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
            chk("out_valid", 32'(out_valid), 32'(busy && cyc >= exp_cyc));
            if (out_valid) begin
                chk("out_data", 32'(out_data), 32'(exp_data));
                chk("out_err", 32'(out_err), 32'(exp_err));
            end
            chk("jobs_done", 32'(jobs_done), 32'(16'(accepted)));
            if (out_valid && !prev_valid) lat = cyc - st;
            prev_valid = out_valid;
            if (out_valid && out_ready) begin
                res_q.push_back('{out_err, out_data, lat});
                accepted++;
                busy = 0;
            end
            if (in_valid && in_ready) begin
                mq.push_back(in_data);
                last_push = cyc;
            end
        end
    end

    task automatic push(input logic [15:0] n, input int l, input int d);
        cfg_t c;
        c.l = l;
        c.d = d;
        cfg_q.push_back(c);
        in_valid = 1;
        in_data = n;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("push_accept", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 0;
        in_data = 16'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while ((busy || mq.size() != 0 || out_valid) && k < 3000);
        chk("idle_reached", 32'(k < 3000), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_res(input int i, input logic [15:0] d, input logic e, input int l);
        chk($sformatf("res%0d_present", i), 32'(res_q.size() > i), 1);
        if (res_q.size() > i) begin
            chk($sformatf("res%0d_data", i), 32'(res_q[i].data), 32'(d));
            chk($sformatf("res%0d_err", i), 32'(res_q[i].err), 32'(e));
            if (l >= 0) chk($sformatf("res%0d_lat", i), res_q[i].lat, l);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 0;

        // Single job: issue latency, result and completion count.
        out_ready = 1;
        res_q.delete();
        s0 = starts;
        push(10, 4, 1);
        wait_idle();
        chk("t1_starts", starts - s0, 1);
        chk("t1_issue_lat", last_start - last_push, 2);
        check_res(0, 16'd55, 0, 5);
        chk("t1_jobs_done", 32'(jobs_done), 1);

        // Back-to-back small and large indices.
        res_q.delete();
        s0 = starts;
        push(0, 3, 1);
        push(1, 2, 1);
        push(2, 5, 2);
        push(24, 4, 3);
        wait_idle();
        chk("t2_starts", starts - s0, 4);
        check_res(0, 16'd0, 0, 4);
        check_res(1, 16'd1, 0, 3);
        check_res(2, 16'd1, 0, 6);
        check_res(3, 16'd46368, 0, 5);

        // Backpressure fills the FIFO and holds off the sixth request.
        out_ready = 0;
        res_q.delete();
        s0 = starts;
        fork
            for (int i = 0; i < 6; i++) push(16'(3 + i), 4, 1);
            begin
                repeat (25) @(negedge clk);
                #1;
                chk("t3_full", 32'(in_ready), 0);
                chk("t3_starts", starts - s0, 1);
                @(posedge clk);
                #1;
                out_ready = 1;
            end
        join
        wait_idle();
        chk("t3_total", starts - s0, 6);
        check_res(0, 16'd2, 0, -1);
        check_res(1, 16'd3, 0, -1);
        check_res(2, 16'd5, 0, -1);
        check_res(3, 16'd8, 0, -1);
        check_res(4, 16'd13, 0, -1);
        check_res(5, 16'd21, 0, -1);

        // Watchdog: stuck core, recovery, and the done-vs-timeout boundary.
        res_q.delete();
        push(7, STUCK, 1);
        push(5, 4, 1);
        push(9, 20, 2);
        push(11, 21, 2);
        wait_idle();
        check_res(0, 16'hFFFF, 1, 21);
        check_res(1, 16'd5, 0, 5);
        check_res(2, 16'd34, 0, 21);
        check_res(3, 16'hFFFF, 1, 21);

        // done left high by the previous job must fall and rise again.
        res_q.delete();
        push(12, 3, 1);
        push(13, 7, 4);
        wait_idle();
        check_res(0, 16'd144, 0, 4);
        check_res(1, 16'd233, 0, 8);

        // Reset while waiting on the core with two requests queued.
        out_ready = 0;
        push(20, 15, 1);
        push(21, 4, 1);
        push(22, 4, 1);
        @(posedge clk);
        #2;
        reset = 1;
        #1;
        chk("t6_in_ready", 32'(in_ready), 1);
        chk("t6_out_valid", 32'(out_valid), 0);
        chk("t6_out_data", 32'(out_data), 0);
        chk("t6_fib_start", 32'(fib_start), 0);
        chk("t6_fib_din", 32'(fib_din), 0);
        chk("t6_jobs_done", 32'(jobs_done), 0);
        cfg_q.delete();
        s0 = starts;
        @(posedge clk);
        #2;
        reset = 0;
        repeat (30) @(negedge clk);
        #1;
        chk("t6_no_start", starts - s0, 0);
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure and core timing.
        res_q.delete();
        fork
            begin
                for (int j = 0; j < 150; j++) begin
                    int d;
                    int l;
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    d = $urandom_range(1, 4);
                    l = ($urandom_range(0, 9) == 0) ? STUCK : $urandom_range(d + 1, 22);
                    push(16'($urandom_range(0, 100)), l, d);
                end
                rand_done = 1;
            end
            while (!rand_done) begin
                @(posedge clk);
                #1;
                out_ready = $urandom_range(0, 2) != 0;
            end
        join
        out_ready = 1;
        wait_idle();
        chk("rand_returned", res_q.size(), 150);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
